// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC switch.
//   NUM_PORTS / PORT_W : switch port count and the width of one port index
//   NORTH..EAST        : direction encoding of the port indices
//   out_state_t        : per-output reservation state (FREE / LOCKED)
package noc_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = $clog2(NUM_PORTS);

  localparam logic [PORT_W-1:0] NORTH = PORT_W'(0);
  localparam logic [PORT_W-1:0] SOUTH = PORT_W'(1);
  localparam logic [PORT_W-1:0] WEST  = PORT_W'(2);
  localparam logic [PORT_W-1:0] EAST  = PORT_W'(3);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } out_state_t;
endpackage

// File: rtl/route_allocator_if.sv
// Request/grant bundle between the head-flit buffers and the output allocator.
//   req_valid    : per-input route-reservation request
//   req_port     : per-input requested output (field i = bits i*W +: W)
//   tail_release : per-input one-cycle pulse, tail flit forwarded
//                  (named tail_release because "release" is a reserved word)
//   grant        : per-input one-cycle acceptance pulse
//   sel          : per-output index of the driving input
//   out_locked   : per-output reservation flag
//   in_locked    : per-input "owns an output" flag
// Modports: master = buffer side (drives requests), slave = allocator side.
interface route_allocator_if
  import noc_pkg::*;
#(
  parameter int N = NUM_PORTS,
  parameter int W = PORT_W
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_port;
  logic [N-1:0]   tail_release;
  logic [N-1:0]   grant;
  logic [N*W-1:0] sel;
  logic [N-1:0]   out_locked;
  logic [N-1:0]   in_locked;

  modport master (
    output req_valid, req_port, tail_release,
    input  grant, sel, out_locked, in_locked
  );

  modport slave (
    input  req_valid, req_port, tail_release,
    output grant, sel, out_locked, in_locked
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : when high and something is granted, pointer moves past winner
//   gnt      : one-hot grant (combinational from req and the pointer)
// The pointer arithmetic wraps modulo 2**W, so N must be a power of two.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  always_comb begin
    logic [W-1:0] idx;
    logic         found;
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = '0;
    // Scan from the pointer upward; the first requester found wins.
    for (int k = 0; k < N; k++) begin
      idx = ptr_reg + W'(k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (advance) ptr_next = idx + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/route_allocator.sv
// Per-switch output allocator: round-robin arbitration per output, output
// locked to its winner until the winner's tail flit is released.
//   clk, rst : clock, synchronous active-high reset (drops every lock)
//   bus      : route_allocator_if slave (requests in; grant/sel/locks out)
// All outputs are registered; a request sampled at one edge is reflected
// in grant/sel/out_locked/in_locked right after that edge.
module route_allocator
  import noc_pkg::*;
#(
  parameter int N = NUM_PORTS,
  parameter int W = PORT_W
) (
  input logic              clk,
  input logic              rst,
  route_allocator_if.slave bus
);
  out_state_t     state_reg [N];
  out_state_t     state_next [N];
  logic [N*W-1:0] sel_reg;
  logic [N*W-1:0] sel_next;
  logic [N-1:0]   grant_reg;
  logic [N-1:0]   grant_next;
  logic [N-1:0]   in_locked_reg;
  logic [N-1:0]   in_locked_next;
  logic [N-1:0]   elig [N];
  logic [N-1:0]   arb_gnt [N];

  // An input that already owns an output is invisible to arbitration, which
  // also swallows a request lingering one cycle past its grant.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      elig[o] = '0;
      for (int i = 0; i < N; i++) begin
        elig[o][i] = bus.req_valid[i] & ~in_locked_reg[i] &
                     (bus.req_port[i*W +: W] == W'(o));
      end
    end
  end

  // Pointer only moves while the output is FREE, i.e. when a grant locks it.
  for (genvar go = 0; go < N; go++) begin : g_out
    rr_arbiter #(.N(N), .W(W)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (elig[go]),
      .advance (state_reg[go] == FREE),
      .gnt     (arb_gnt[go])
    );
    assign bus.out_locked[go] = (state_reg[go] == LOCKED);
  end

  // The sel field doubles as the owner register: it is written only on lock
  // and held through the LOCKED interval (and afterwards while FREE).
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    grant_next     = '0;
    in_locked_next = in_locked_reg;
    for (int o = 0; o < N; o++) begin
      case (state_reg[o])
        FREE: begin
          if (|arb_gnt[o]) begin
            state_next[o] = LOCKED;
            for (int i = 0; i < N; i++) begin
              if (arb_gnt[o][i]) begin
                sel_next[o*W +: W] = W'(i);
                grant_next[i]      = 1'b1;
                in_locked_next[i]  = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (bus.tail_release[sel_reg[o*W +: W]]) begin
            state_next[o]                      = FREE;
            in_locked_next[sel_reg[o*W +: W]]  = 1'b0;
          end
        end
        default: state_next[o] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N; o++) state_reg[o] <= FREE;
      sel_reg       <= '0;
      grant_reg     <= '0;
      in_locked_reg <= '0;
    end else begin
      for (int o = 0; o < N; o++) state_reg[o] <= state_next[o];
      sel_reg       <= sel_next;
      grant_reg     <= grant_next;
      in_locked_reg <= in_locked_next;
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.sel       = sel_reg;
  assign bus.in_locked = in_locked_reg;
endmodule

// File: tb/tb_route_allocator.sv
module tb_route_allocator;
  import noc_pkg::*;

  localparam int N  = NUM_PORTS;
  localparam int W  = PORT_W;
  localparam int VW = 3*N + N*W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  route_allocator_if #(.N(N), .W(W)) bus ();
  route_allocator #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Reference model: who owns each output (-1 = nobody), priority pointer,
  // last selected input per output, and the grants of the latest edge.
  int           m_owner [N];
  int           m_ptr [N];
  int           m_sel [N];
  logic [N-1:0] m_grant;

  function automatic bit m_owns(int i);
    bit r = 1'b0;
    for (int o = 0; o < N; o++) if (m_owner[o] == i) r = 1'b1;
    return r;
  endfunction

  function automatic logic [VW-1:0] model_view();
    logic [N-1:0]   ol = '0;
    logic [N-1:0]   il = '0;
    logic [N*W-1:0] s  = '0;
    for (int o = 0; o < N; o++) begin
      s[o*W +: W] = W'(m_sel[o]);
      if (m_owner[o] >= 0) begin
        ol[o]          = 1'b1;
        il[m_owner[o]] = 1'b1;
      end
    end
    return {m_grant, s, ol, il};
  endfunction

  function automatic logic [VW-1:0] dut_view();
    return {bus.grant, bus.sel, bus.out_locked, bus.in_locked};
  endfunction

  // One clock: apply the allocation rules to the inputs seen at the edge,
  // then move to 1 time unit after the edge for sampling.
  task automatic tick();
    logic [N-1:0]   rv;
    logic [N-1:0]   rl;
    logic [N*W-1:0] rp;
    int             nown [N];
    logic [N-1:0]   ng;
    bit             done;
    int             cand;
    @(posedge clk);
    rv = bus.req_valid;
    rl = bus.tail_release;
    rp = bus.req_port;
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        m_owner[o] = -1; m_ptr[o] = 0; m_sel[o] = 0;
      end
      m_grant = '0;
    end else begin
      ng = '0;
      for (int o = 0; o < N; o++) begin
        nown[o] = m_owner[o];
        if (m_owner[o] >= 0) begin
          if (rl[m_owner[o]]) nown[o] = -1;
        end else begin
          done = 1'b0;
          for (int k = 0; k < N; k++) begin
            cand = (m_ptr[o] + k) % N;
            if (!done && rv[cand] && !m_owns(cand) && int'(rp[cand*W +: W]) == o) begin
              done = 1'b1;
              nown[o] = cand; ng[cand] = 1'b1; m_sel[o] = cand;
              m_ptr[o] = (cand + 1) % N;
            end
          end
        end
      end
      m_owner = nown;
      m_grant = ng;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_port = '0; bus.tail_release = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick();
    checks++;
    if (dut_view() !== '0) $display("FAIL reset_outputs: got %h expected 0", dut_view());
    else passes++;
    rst = 1'b0; tick();
    checks++;
    if (dut_view() !== model_view()) $display("FAIL reset_idle: got %h expected %h", dut_view(), model_view());
    else passes++;
  endtask

  task automatic test_single_request();
    do_reset();
    tick(); tick(); tick();
    bus.req_valid[2] = 1'b1; bus.req_port[2*W +: W] = EAST;
    tick();
    checks++;
    if (bus.grant !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", bus.grant); else passes++;
    checks++;
    if (bus.sel[3*W +: W] !== W'(2)) $display("FAIL single_sel: got %0d expected 2", bus.sel[3*W +: W]); else passes++;
    checks++;
    if ({bus.out_locked, bus.in_locked} !== 8'b1000_0100)
      $display("FAIL single_locks: got %b/%b expected 1000/0100", bus.out_locked, bus.in_locked);
    else passes++;
    bus.req_valid[2] = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0000 || bus.out_locked !== 4'b1000)
      $display("FAIL single_pulse: got grant %b locked %b expected 0000/1000", bus.grant, bus.out_locked);
    else passes++;
    tick(); tick();
    bus.tail_release[2] = 1'b1; tick(); bus.tail_release[2] = 1'b0;
    checks++;
    if ({bus.out_locked, bus.in_locked} !== 8'b0 || bus.sel[3*W +: W] !== W'(2))
      $display("FAIL single_release: got %b/%b sel %0d expected 0000/0000 sel 2",
               bus.out_locked, bus.in_locked, bus.sel[3*W +: W]);
    else passes++;
  endtask

  task automatic test_sequential_grants();
    int order [3] = '{0, 1, 3};
    int w;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      bus.req_valid[order[n]] = 1'b1; bus.req_port[order[n]*W +: W] = SOUTH;
    end
    tick();
    for (int n = 0; n < 3; n++) begin
      w = order[n];
      checks++;
      if (bus.grant !== N'(1 << w) || bus.sel[SOUTH*W +: W] !== W'(w))
        $display("FAIL seq_grant%0d: got %b sel %0d expected %b sel %0d", n, bus.grant,
                 bus.sel[SOUTH*W +: W], N'(1 << w), w);
      else passes++;
      bus.req_valid[w] = 1'b0;
      tick(); tick();
      bus.tail_release[w] = 1'b1; tick(); bus.tail_release[w] = 1'b0;
      checks++;
      if (bus.grant !== '0 || bus.out_locked[SOUTH] !== 1'b0)
        $display("FAIL seq_gap%0d: got grant %b locked %b expected 0000/0", n, bus.grant, bus.out_locked[SOUTH]);
      else passes++;
      tick();
    end
    checks++;
    if (bus.grant !== '0 || bus.out_locked !== '0)
      $display("FAIL seq_end: got grant %b locked %b expected 0000/0000", bus.grant, bus.out_locked);
    else passes++;
  endtask

  task automatic test_fairness();
    int seen = 0;
    int owner = -1;
    int hold = 0;
    int exp_w;
    do_reset();
    bus.req_valid[0] = 1'b1; bus.req_port[0*W +: W] = WEST;
    bus.req_valid[2] = 1'b1; bus.req_port[2*W +: W] = WEST;
    for (int c = 0; c < 80 && seen < 6; c++) begin
      bus.tail_release = '0;
      if (owner >= 0) begin
        hold++;
        if (hold == 3) begin bus.tail_release[owner] = 1'b1; owner = -1; end
      end
      tick();
      checks++;
      if (dut_view() !== model_view()) $display("FAIL fair_model: got %h expected %h", dut_view(), model_view());
      else passes++;
      if (m_grant != '0) begin
        exp_w = (seen % 2 == 0) ? 0 : 2;
        checks++;
        if (bus.grant !== N'(1 << exp_w))
          $display("FAIL fair_order%0d: got %b expected %b", seen, bus.grant, N'(1 << exp_w));
        else passes++;
        for (int i = 0; i < N; i++) if (m_grant[i]) owner = i;
        hold = 0;
        seen++;
      end
    end
    checks++;
    if (seen != 6) $display("FAIL fair_timeout: got %0d grants expected 6", seen); else passes++;
    idle_inputs();
  endtask

  task automatic test_parallel();
    do_reset();
    bus.req_valid = '1;
    bus.req_port  = {WEST, EAST, NORTH, SOUTH};
    tick();
    checks++;
    if (bus.grant !== 4'b1111) $display("FAIL par_grant: got %b expected 1111", bus.grant); else passes++;
    checks++;
    if (bus.sel !== {W'(2), W'(3), W'(0), W'(1)}) $display("FAIL par_sel: got %h expected b1", bus.sel);
    else passes++;
    checks++;
    if ({bus.out_locked, bus.in_locked} !== 8'hFF)
      $display("FAIL par_locks: got %b/%b expected 1111/1111", bus.out_locked, bus.in_locked);
    else passes++;
    bus.req_valid = '0; bus.tail_release = '1;
    tick();
    bus.tail_release = '0;
    checks++;
    if ({bus.out_locked, bus.in_locked} !== 8'h00)
      $display("FAIL par_release: got %b/%b expected 0000/0000", bus.out_locked, bus.in_locked);
    else passes++;
  endtask

  task automatic test_corners();
    do_reset();
    // Request held for two cycles beyond its grant.
    bus.req_valid[1] = 1'b1; bus.req_port[1*W +: W] = NORTH;
    tick();
    checks++;
    if (bus.grant !== 4'b0010) $display("FAIL hold_grant: got %b expected 0010", bus.grant); else passes++;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0000 || bus.in_locked !== 4'b0010)
        $display("FAIL hold_regrant%0d: got %b/%b expected 0000/0010", c, bus.grant, bus.in_locked);
      else passes++;
    end
    bus.req_valid[1] = 1'b0;
    // Release from an input that owns nothing.
    bus.req_valid[0] = 1'b1; bus.req_port[0*W +: W] = WEST;
    tick();
    bus.req_valid[0] = 1'b0;
    bus.tail_release[3] = 1'b1; tick(); bus.tail_release[3] = 1'b0;
    checks++;
    if ({bus.grant, bus.out_locked, bus.in_locked} !== 12'b0000_0101_0011)
      $display("FAIL stray_release: got %b/%b/%b expected 0000/0101/0011", bus.grant, bus.out_locked, bus.in_locked);
    else passes++;
    // Request for a locked output withdrawn before it could win.
    bus.req_valid[2] = 1'b1; bus.req_port[2*W +: W] = WEST;
    tick(); tick();
    bus.req_valid[2] = 1'b0;
    bus.tail_release[0] = 1'b1; tick(); bus.tail_release[0] = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 4'b0000 || bus.out_locked[WEST] !== 1'b0)
      $display("FAIL withdraw: got grant %b locked %b expected 0000/0", bus.grant, bus.out_locked[WEST]);
    else passes++;
    // Pointer of WEST is still just past input 0, so input 2 beats input 3.
    bus.req_valid[2] = 1'b1; bus.req_valid[3] = 1'b1; bus.req_port[3*W +: W] = WEST;
    tick();
    checks++;
    if (bus.grant !== 4'b0100) $display("FAIL withdraw_ptr: got %b expected 0100", bus.grant); else passes++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = '1;
    bus.req_port  = {WEST, EAST, NORTH, SOUTH};
    tick();
    bus.req_valid = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (dut_view() !== '0) $display("FAIL midrst_clear: got %h expected 0", dut_view()); else passes++;
    // SOUTH pointer back at input 0; input 3 takes NORTH one cycle later.
    bus.req_valid = 4'b1011;
    bus.req_port  = {NORTH, NORTH, SOUTH, SOUTH};
    tick();
    checks++;
    if (bus.grant !== 4'b1001 || bus.sel[NORTH*W +: W] !== W'(3) || bus.sel[SOUTH*W +: W] !== W'(0))
      $display("FAIL midrst_regrant: got %b sel %h expected 1001 sel N=3 S=0", bus.grant, bus.sel);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_random();
    bit owns;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.tail_release[i] = 1'b0;
        owns = m_owns(i);
        if (owns) begin
          if ($urandom_range(3) == 0) bus.tail_release[i] = 1'b1;
          if ($urandom_range(2) != 0) bus.req_valid[i] = 1'b0;
        end else if (bus.req_valid[i]) begin
          if ($urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_port[i*W +: W] = W'($urandom_range(N-1));
        end
        if (!owns && $urandom_range(7) == 0) bus.tail_release[i] = 1'b1;
      end
      rst = ($urandom_range(149) == 0);
      tick();
      checks++;
      if (dut_view() !== model_view())
        $display("FAIL random_c%0d: got %h expected %h", c, dut_view(), model_view());
      else passes++;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int o = 0; o < N; o++) begin m_owner[o] = -1; m_ptr[o] = 0; m_sel[o] = 0; end
    m_grant = '0;
    test_reset();
    test_single_request();
    test_sequential_grants();
    test_fairness();
    test_parallel();
    test_corners();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
